// File: rtl/fe_data_tx_pkg.sv
// Shared constants, state type and K-code helpers for the fe_data_tx serial transmitter.
package fe_data_tx_pkg;

  // K28.5 comma code words, bit 9 = 'a' (first bit on the wire)
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // Default idle character (K28.5) and comma count before data is accepted
  localparam logic [7:0] IDLE_CHAR_DEF = 8'hBC;
  localparam int         IDLE_MIN_DEF  = 4;

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_SYNC,
    ST_RUN
  } tx_state_t;

  // Only these K characters have a defined 8b10b code:
  // K28.0-K28.7, K23.7, K27.7, K29.7, K30.7
  function automatic logic is_valid_k(input logic [7:0] b);
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fe_data_tx_encode_8b10b.sv
// Combinational 8b10b encoder (IEEE 802.3 clause 36). Code word order is
// {a,b,c,d,e,i,f,g,h,j} with bit 9 = a. Unsupported K bytes are replaced by
// IDLE_CHAR and flagged on k_err.
module encode_8b10b
  import fe_data_tx_pkg::*;
#(
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF
) (
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_err
);

  logic [7:0] eff;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] t6;
  logic [3:0] t4;
  logic [5:0] c6;
  logic [3:0] c4;
  logic       rd6;
  logic       use_a7;

  // Sub-block lookup: tables hold the RD- form; RD+ form is the complement
  // for unbalanced codes, D.7 (111000) and D.x.3 / all K 3b4b entries.
  always_comb begin
    k_err  = k && !is_valid_k(data);
    eff    = k_err ? IDLE_CHAR : data;
    x      = eff[4:0];
    y      = eff[7:5];
    t6     = 6'b000000;
    t4     = 4'b0000;
    use_a7 = 1'b0;

    if (k && x == 5'd28) begin
      t6 = 6'b001111;
    end else begin
      case (x)
        5'd0:  t6 = 6'b100111;
        5'd1:  t6 = 6'b011101;
        5'd2:  t6 = 6'b101101;
        5'd3:  t6 = 6'b110001;
        5'd4:  t6 = 6'b110101;
        5'd5:  t6 = 6'b101001;
        5'd6:  t6 = 6'b011001;
        5'd7:  t6 = 6'b111000;
        5'd8:  t6 = 6'b111001;
        5'd9:  t6 = 6'b100101;
        5'd10: t6 = 6'b010101;
        5'd11: t6 = 6'b110100;
        5'd12: t6 = 6'b001101;
        5'd13: t6 = 6'b101100;
        5'd14: t6 = 6'b011100;
        5'd15: t6 = 6'b010111;
        5'd16: t6 = 6'b011011;
        5'd17: t6 = 6'b100011;
        5'd18: t6 = 6'b010011;
        5'd19: t6 = 6'b110010;
        5'd20: t6 = 6'b001011;
        5'd21: t6 = 6'b101010;
        5'd22: t6 = 6'b011010;
        5'd23: t6 = 6'b111010;
        5'd24: t6 = 6'b110011;
        5'd25: t6 = 6'b100110;
        5'd26: t6 = 6'b010110;
        5'd27: t6 = 6'b110110;
        5'd28: t6 = 6'b001110;
        5'd29: t6 = 6'b101110;
        5'd30: t6 = 6'b011110;
        5'd31: t6 = 6'b101011;
        default: t6 = 6'b000000;
      endcase
    end

    c6  = (rd_in && ($countones(t6) != 3 || (!k && x == 5'd7))) ? ~t6 : t6;
    rd6 = ($countones(t6) != 3) ? ~rd_in : rd_in;

    // A7 avoids a run of five equal bits across the sub-block boundary
    use_a7 = !k && y == 3'd7 &&
             ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

    if (k) begin
      case (y)
        3'd0: t4 = 4'b1011;
        3'd1: t4 = 4'b0110;
        3'd2: t4 = 4'b1010;
        3'd3: t4 = 4'b1100;
        3'd4: t4 = 4'b1101;
        3'd5: t4 = 4'b0101;
        3'd6: t4 = 4'b1001;
        default: t4 = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: t4 = 4'b1011;
        3'd1: t4 = 4'b1001;
        3'd2: t4 = 4'b0101;
        3'd3: t4 = 4'b1100;
        3'd4: t4 = 4'b1101;
        3'd5: t4 = 4'b1010;
        3'd6: t4 = 4'b0110;
        default: t4 = use_a7 ? 4'b0111 : 4'b1110;
      endcase
    end

    c4     = (rd6 && (k || $countones(t4) != 2 || y == 3'd3)) ? ~t4 : t4;
    rd_out = ($countones(t4) != 2) ? ~rd6 : rd6;
    code   = {c6, c4};
  end

endmodule

// File: rtl/fe_data_tx.sv
// 8b10b serial transmitter: sends IDLE_MIN commas after enable/reset, then
// accepts one byte per 10-bit character over a valid/ready handshake and
// shifts the code word out MSB first, idling with K28.5 when no data is offered.
module fe_data_tx
  import fe_data_tx_pkg::*;
#(
  parameter int         IDLE_MIN  = IDLE_MIN_DEF,
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_K,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       TX_OUT,
  output logic       SYNC_DONE,
  output logic       K_ERR,
  output logic       RD
);

  localparam int CW = $clog2(IDLE_MIN + 1);

  tx_state_t       state;
  tx_state_t       next_state;
  logic [3:0]      bit_cnt;
  logic [CW-1:0]   comma_cnt;
  logic [CW-1:0]   comma_next;
  logic [9:0]      shift;
  logic            rd;
  logic            k_err_q;

  logic            boundary;
  logic            load;
  logic            take;
  logic [7:0]      enc_data;
  logic            enc_k;
  logic [9:0]      enc_code;
  logic            enc_rd;
  logic            enc_kerr;

  assign boundary   = (bit_cnt == 4'd9);
  assign DATA_READY = (state == ST_RUN) && ENABLE && boundary;
  assign take       = DATA_READY && DATA_VALID;
  assign load       = ENABLE && ((state == ST_DISABLED) || boundary);
  assign enc_data   = take ? DATA_IN : IDLE_CHAR;
  assign enc_k      = take ? DATA_K : 1'b1;
  assign comma_next = (state == ST_DISABLED) ? CW'(1) : comma_cnt + CW'(1);

  assign TX_OUT    = shift[9];
  assign SYNC_DONE = (state == ST_RUN);
  assign K_ERR     = k_err_q;
  assign RD        = rd;

  encode_8b10b #(
    .IDLE_CHAR(IDLE_CHAR)
  ) u_enc (
    .data   (enc_data),
    .k      (enc_k),
    .rd_in  (rd),
    .code   (enc_code),
    .rd_out (enc_rd),
    .k_err  (enc_kerr)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_DISABLED;
    else     state <= next_state;
  end

  // Next state: disable dominates; RUN is entered on the load of the last sync comma
  always_comb begin
    next_state = state;
    if (!ENABLE) begin
      next_state = ST_DISABLED;
    end else if (load && state != ST_RUN && comma_next == CW'(IDLE_MIN)) begin
      next_state = ST_RUN;
    end else if (state == ST_DISABLED) begin
      next_state = ST_SYNC;
    end
  end

  // Datapath: load a new word at each boundary, otherwise shift; clear everything when disabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt   <= 4'd0;
      comma_cnt <= '0;
      shift     <= 10'd0;
      rd        <= 1'b0;
      k_err_q   <= 1'b0;
    end else if (!ENABLE) begin
      bit_cnt   <= 4'd0;
      comma_cnt <= '0;
      shift     <= 10'd0;
      rd        <= 1'b0;
      k_err_q   <= 1'b0;
    end else if (load) begin
      bit_cnt   <= 4'd0;
      shift     <= enc_code;
      rd        <= enc_rd;
      k_err_q   <= take && enc_kerr;
      if (state != ST_RUN) comma_cnt <= comma_next;
    end else begin
      bit_cnt   <= bit_cnt + 4'd1;
      shift     <= {shift[8:0], 1'b0};
      k_err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fe_data_tx.sv
// Directed self-checking bench for fe_data_tx: captures each 10-bit character
// from TX_OUT and compares it with hand-computed 8b10b code words.
module tb_fe_data_tx;

  localparam logic [9:0] C_RDN   = 10'b0011111010;
  localparam logic [9:0] C_RDP   = 10'b1100000101;
  localparam logic [9:0] C_D00   = 10'b1001110100;
  localparam logic [9:0] C_D215  = 10'b1010101010;
  localparam logic [9:0] C_K281P = 10'b1100000110;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ENABLE;
  logic [7:0] DATA_IN;
  logic       DATA_K;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       TX_OUT;
  logic       SYNC_DONE;
  logic       K_ERR;
  logic       RD;

  int checks   = 0;
  int failures = 0;

  logic [9:0] cw;
  logic       c_rd0, c_sd0, c_kerr0;
  int         c_rdy, c_take, c_kerr;

  fe_data_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENABLE     (ENABLE),
    .DATA_IN    (DATA_IN),
    .DATA_K     (DATA_K),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TX_OUT     (TX_OUT),
    .SYNC_DONE  (SYNC_DONE),
    .K_ERR      (K_ERR),
    .RD         (RD)
  );

  always #5 CLK = ~CLK;

  // Capture one character starting at bit 0 (negedge sampling); ends at bit 0 of the next
  task automatic get_char();
    cw = '0; c_rdy = 0; c_take = 0; c_kerr = 0;
    c_rd0 = RD; c_sd0 = SYNC_DONE; c_kerr0 = K_ERR;
    for (int j = 0; j < 10; j++) begin
      cw[9-j] = TX_OUT;
      if (DATA_READY) c_rdy++;
      if (DATA_READY && DATA_VALID) c_take++;
      if (K_ERR) c_kerr++;
      @(posedge CLK); @(negedge CLK);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); @(negedge CLK);
    end
  endtask

  // Four commas alternating RD, SYNC_DONE on the 4th, single DATA_READY at its end
  task automatic test_sync(input string tag);
    logic [9:0] exp_w [4];
    logic       exp_rd [4];
    logic       exp_sd [4];
    int         exp_rdy [4];
    exp_w   = '{C_RDN, C_RDP, C_RDN, C_RDP};
    exp_rd  = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_sd  = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_rdy = '{0, 0, 0, 1};
    for (int c = 0; c < 4; c++) begin
      get_char();
      if (cw !== exp_w[c]) begin failures++; $display("[TB] FAIL %s_word%0d got=%b exp=%b", tag, c, cw, exp_w[c]); end
      checks++;
      if (c_rd0 !== exp_rd[c]) begin failures++; $display("[TB] FAIL %s_rd%0d got=%b exp=%b", tag, c, c_rd0, exp_rd[c]); end
      checks++;
      if (c_sd0 !== exp_sd[c]) begin failures++; $display("[TB] FAIL %s_sync_done%0d got=%b exp=%b", tag, c, c_sd0, exp_sd[c]); end
      checks++;
      if (c_rdy !== exp_rdy[c]) begin failures++; $display("[TB] FAIL %s_ready%0d got=%0d exp=%0d", tag, c, c_rdy, exp_rdy[c]); end
      checks++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; ENABLE = 1'b1; DATA_IN = 8'h00; DATA_K = 1'b0; DATA_VALID = 1'b0;
    step(3);
    if (TX_OUT !== 1'b0)     begin failures++; $display("[TB] FAIL reset_tx got=%b exp=0", TX_OUT); end
    checks++;
    if (DATA_READY !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", DATA_READY); end
    checks++;
    if (SYNC_DONE !== 1'b0)  begin failures++; $display("[TB] FAIL reset_sync_done got=%b exp=0", SYNC_DONE); end
    checks++;
    if (K_ERR !== 1'b0)      begin failures++; $display("[TB] FAIL reset_k_err got=%b exp=0", K_ERR); end
    checks++;
    if (RD !== 1'b0)         begin failures++; $display("[TB] FAIL reset_rd got=%b exp=0", RD); end
    checks++;
    // D.00 offered during sync must wait until RUN
    DATA_VALID = 1'b1;
    RST = 1'b0;
    step(1);
    test_sync("boot");
  endtask

  task automatic test_d00();
    DATA_VALID = 1'b0;
    get_char();
    if (cw !== C_D00)  begin failures++; $display("[TB] FAIL d00_word got=%b exp=%b", cw, C_D00); end
    checks++;
    if (c_rd0 !== 1'b0) begin failures++; $display("[TB] FAIL d00_rd got=%b exp=0", c_rd0); end
    checks++;
    if (c_take !== 0)   begin failures++; $display("[TB] FAIL d00_take got=%0d exp=0", c_take); end
    checks++;
  endtask

  task automatic test_d21_5();
    DATA_IN = 8'hB5; DATA_K = 1'b0; DATA_VALID = 1'b1;
    get_char();
    if (cw !== C_RDN)  begin failures++; $display("[TB] FAIL d215_comma got=%b exp=%b", cw, C_RDN); end
    checks++;
    for (int c = 0; c < 2; c++) begin
      get_char();
      if (cw !== C_D215)  begin failures++; $display("[TB] FAIL d215_word%0d got=%b exp=%b", c, cw, C_D215); end
      checks++;
      if (c_rd0 !== 1'b1) begin failures++; $display("[TB] FAIL d215_rd%0d got=%b exp=1", c, c_rd0); end
      checks++;
      if (c_take !== 1)   begin failures++; $display("[TB] FAIL d215_take%0d got=%0d exp=1", c, c_take); end
      checks++;
    end
  endtask

  task automatic test_invalid_k();
    DATA_K = 1'b1; DATA_IN = 8'h1D;
    get_char();
    if (cw !== C_D215) begin failures++; $display("[TB] FAIL badk_prev_word got=%b exp=%b", cw, C_D215); end
    checks++;
    if (c_kerr !== 0)  begin failures++; $display("[TB] FAIL badk_prev_kerr got=%0d exp=0", c_kerr); end
    checks++;
    DATA_VALID = 1'b0; DATA_K = 1'b0;
    get_char();
    if (cw !== C_RDP)    begin failures++; $display("[TB] FAIL badk_word got=%b exp=%b", cw, C_RDP); end
    checks++;
    if (c_kerr0 !== 1'b1) begin failures++; $display("[TB] FAIL badk_kerr_first got=%b exp=1", c_kerr0); end
    checks++;
    if (c_kerr !== 1)    begin failures++; $display("[TB] FAIL badk_kerr_len got=%0d exp=1", c_kerr); end
    checks++;
    if (c_rd0 !== 1'b0)  begin failures++; $display("[TB] FAIL badk_rd got=%b exp=0", c_rd0); end
    checks++;
  endtask

  task automatic test_valid_k();
    DATA_K = 1'b1; DATA_IN = 8'h3C; DATA_VALID = 1'b1;
    get_char();
    if (cw !== C_RDN)   begin failures++; $display("[TB] FAIL k281_comma got=%b exp=%b", cw, C_RDN); end
    checks++;
    DATA_VALID = 1'b0; DATA_K = 1'b0;
    get_char();
    if (cw !== C_K281P) begin failures++; $display("[TB] FAIL k281_word got=%b exp=%b", cw, C_K281P); end
    checks++;
    if (c_kerr !== 0)   begin failures++; $display("[TB] FAIL k281_kerr got=%0d exp=0", c_kerr); end
    checks++;
    if (c_rd0 !== 1'b0) begin failures++; $display("[TB] FAIL k281_rd got=%b exp=0", c_rd0); end
    checks++;
  endtask

  task automatic test_enable_drop();
    int stray;
    // Next character is a comma at RD-, so RD is 1 and bit 5 would be 1
    step(4);
    ENABLE = 1'b0;
    step(1);
    if (TX_OUT !== 1'b0)     begin failures++; $display("[TB] FAIL dis_tx got=%b exp=0", TX_OUT); end
    checks++;
    if (SYNC_DONE !== 1'b0)  begin failures++; $display("[TB] FAIL dis_sync_done got=%b exp=0", SYNC_DONE); end
    checks++;
    if (RD !== 1'b0)         begin failures++; $display("[TB] FAIL dis_rd got=%b exp=0", RD); end
    checks++;
    DATA_IN = 8'hB5; DATA_K = 1'b0; DATA_VALID = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      if (TX_OUT || DATA_READY) stray++;
      step(1);
    end
    if (stray !== 0) begin failures++; $display("[TB] FAIL dis_idle_activity got=%0d exp=0", stray); end
    checks++;
    ENABLE = 1'b1;
    step(1);
    test_sync("reen");
    get_char();
    if (cw !== C_D215)  begin failures++; $display("[TB] FAIL reen_data got=%b exp=%b", cw, C_D215); end
    checks++;
  endtask

  task automatic test_reset_mid();
    step(4);
    if (TX_OUT !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre_tx got=%b exp=1", TX_OUT); end
    checks++;
    DATA_IN = 8'h00;
    #2 RST = 1'b1;
    #1;
    if (TX_OUT !== 1'b0)     begin failures++; $display("[TB] FAIL rstmid_tx got=%b exp=0", TX_OUT); end
    checks++;
    if (SYNC_DONE !== 1'b0)  begin failures++; $display("[TB] FAIL rstmid_sync_done got=%b exp=0", SYNC_DONE); end
    checks++;
    if (DATA_READY !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ready got=%b exp=0", DATA_READY); end
    checks++;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    step(1);
    test_sync("rst");
    DATA_VALID = 1'b0;
    get_char();
    if (cw !== C_D00)   begin failures++; $display("[TB] FAIL rstmid_data got=%b exp=%b", cw, C_D00); end
    checks++;
    if (c_rd0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rd got=%b exp=0", c_rd0); end
    checks++;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_d00();
    test_d21_5();
    test_invalid_k();
    test_valid_k();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
